piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly downstream of the bit-reversal block.
- Accepts a DATA_WIDTH-bit word over a valid/ready handshake and emits it one bit per accepted beat.
- Bit order is selectable, so word orientation fixed by the reversal stage can be kept or undone on the serial line.
- Supports back-to-back words with no bubble.

Parameters:
- DATA_WIDTH, 8, word width in bits; legal range is 2 or more.
- LSB_FIRST, 0, 0 = emit din[DATA_WIDTH-1] first; 1 = emit din[0] first.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous reset, active-low
- din  input  DATA_WIDTH  parallel word to serialize
- din_valid  input  1  din holds a word
- din_ready  output  1  block accepts din this cycle
- dout  output  1  current serial bit
- dout_valid  output  1  dout holds a valid bit
- dout_last  output  1  dout is the final bit of the word
- dout_ready  input  1  downstream consumes dout this cycle

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (resetn), sampled on the rising edge of clk. Polarity and synchronicity are fixed.
- State: IDLE / SHIFT, a DATA_WIDTH-bit shift register, and a bit counter cnt of width $clog2(DATA_WIDTH).
- Reset (resetn=0 at an edge):
  - state=IDLE, cnt=0, shift register=0.
  - Outputs: dout=0, dout_valid=0, dout_last=0.
  - din_ready is forced to 0 while resetn is low.
  - Reset mid-word discards the remaining bits; no partial word is resumed.
- din_ready (combinational):
  - 1 in IDLE.
  - 1 in SHIFT only when dout_valid & dout_ready & dout_last, which gives back-to-back reload.
  - 0 otherwise.
  - This is a permitted combinational path from dout_ready to din_ready.
- Load: din_valid & din_ready at an edge:
  - shift register <= din, cnt <= 0, state <= SHIFT.
  - The first bit is valid in the next cycle.
  - Latency from word accept to first bit valid is 1 cycle.
- Output bit:
  - LSB_FIRST=0: dout = shreg[DATA_WIDTH-1].
  - LSB_FIRST=1: dout = shreg[0].
  - dout=0 whenever dout_valid=0.
- dout_valid = (state==SHIFT).
- dout_last = dout_valid & (cnt==DATA_WIDTH-1).
- Beat (dout_valid & dout_ready at an edge):
  - cnt not last: shift toward the output end (left for MSB-first, right for LSB-first), fill with 0, cnt <= cnt+1.
  - cnt last, with a load in the same cycle: reload per Load rule; state stays SHIFT.
  - cnt last, no load: state <= IDLE, cnt <= 0.
- Backpressure: while dout_ready=0, dout, dout_last, cnt and the shift register hold. dout_valid never drops without a completed beat.
- A word not accepted (din_ready=0) is not sampled. Upstream holds din/din_valid; din changes while din_ready=0 have no effect.
- Throughput: with dout_ready tied high and din_valid continuously high, exactly one word per DATA_WIDTH cycles and dout_valid stays 1 with no gap.
- No other simultaneous-event cases exist: load and beat coincide only on the last bit, which is covered above.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with din_valid=1, din=8'hFF -> dout=0, dout_valid=0, dout_last=0, din_ready=0 every cycle. After release, din_ready=1 in IDLE.
- Single word, LSB_FIRST=0, din=8'hA6 accepted at edge N, dout_ready=1:
  - Cycles N+1..N+8 give dout=1,0,1,0,0,1,1,0.
  - dout_last=1 only in N+8.
  - dout_valid=0 in N+9.
- Back-to-back, dout_ready=1: 8'hA6 then 8'h3C presented immediately.
  - din_ready=1 only in the last-bit cycle of the first word.
  - 16 consecutive valid bits: 1,0,1,0,0,1,1,0,0,0,1,1,1,1,0,0.
  - Never a dout_valid=0 cycle between the words.
- Backpressure: 8'hA6, drop dout_ready for 2 cycles while the 3rd bit (1) is presented.
  - dout=1, dout_valid=1, dout_last=0 hold.
  - The remaining bits resume 0,0,1,1,0 with no loss or duplication.
- Busy input: present 8'h55 with din_valid=1 during bit 2 of 8'hA6.
  - din_ready=0 until the last bit of 8'hA6.
  - 8'h55 is loaded at that edge and then emitted as 0,1,0,1,0,1,0,1.
- Variants:
  - LSB_FIRST=1, din=8'h01 -> dout=1,0,0,0,0,0,0,0.
  - DATA_WIDTH=3, LSB_FIRST=0, din=3'b110 -> 1,1,0 with dout_last on the 3rd bit.
  - resetn=0 on bit 4 of a word -> next cycle dout_valid=0. A fresh 8'hFF then serializes as eight 1s.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes a DATA_WIDTH-bit word over valid/ready
// and emits it one bit per accepted beat, MSB- or LSB-first.
module piso_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter bit LSB_FIRST  = 1'b0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic                  dout,
   output logic                  dout_valid,
   output logic                  dout_last,
   input  logic                  dout_ready
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic                  load, beat;

   assign dout_valid = (state == SHIFT);
   assign dout_last  = dout_valid & (cnt == LAST);
   assign dout       = dout_valid & (LSB_FIRST ? shreg[0] : shreg[DATA_WIDTH-1]);

   // Reload is allowed on the final beat so consecutive words leave no bubble.
   assign din_ready  = resetn & ((state == IDLE) | (dout_valid & dout_ready & dout_last));
   assign load       = din_valid & din_ready;
   assign beat       = dout_valid & dout_ready;

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      if (beat) begin
         if (!dout_last) begin
            shreg_nxt = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
            cnt_nxt   = cnt + 1'b1;
         end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      end
      // A load overrides the end-of-word return to IDLE.
      if (load) begin
         shreg_nxt = din;
         cnt_nxt   = '0;
         state_nxt = SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios plus a randomized run checked
// against a queue-of-bits reference model of the 8-bit MSB-first instance.
module tb_piso_serializer;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   // 8-bit MSB-first instance (main DUT, tracked by the model)
   logic [7:0] din;
   logic       din_valid, din_ready, dout, dout_valid, dout_last, dout_ready;
   // 8-bit LSB-first instance
   logic [7:0] l_din;
   logic       l_dv, l_rdy, l_do, l_dov, l_last, l_drdy;
   // 3-bit MSB-first instance
   logic [2:0] w_din;
   logic       w_dv, w_rdy, w_do, w_dov, w_last, w_drdy;

   piso_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready));

   piso_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .resetn(resetn), .din(l_din), .din_valid(l_dv), .din_ready(l_rdy),
      .dout(l_do), .dout_valid(l_dov), .dout_last(l_last), .dout_ready(l_drdy));

   piso_serializer #(.DATA_WIDTH(3), .LSB_FIRST(1'b0)) u_w3 (
      .clk(clk), .resetn(resetn), .din(w_din), .din_valid(w_dv), .din_ready(w_rdy),
      .dout(w_do), .dout_valid(w_dov), .dout_last(w_last), .dout_ready(w_drdy));

   int total = 0;
   int bad   = 0;

   // Reference model: bits of the word in flight, in emission order.
   bit mq[$];
   bit last_acc = 1'b0;

   function automatic bit m_valid();
      return mq.size() > 0;
   endfunction
   function automatic bit m_dout();
      return (mq.size() > 0) ? mq[0] : 1'b0;
   endfunction
   function automatic bit m_last();
      return mq.size() == 1;
   endfunction
   function automatic bit m_ready();
      return resetn && ((mq.size() == 0) || ((mq.size() == 1) && dout_ready));
   endfunction

   // Advance the model with pre-edge inputs, then cross one rising edge.
   task automatic tick();
      bit rdy;
      rdy = m_ready();
      last_acc = 1'b0;
      if (!resetn) begin
         mq.delete();
      end else begin
         if (m_valid() && dout_ready) void'(mq.pop_front());
         if (din_valid && rdy) begin
            last_acc = 1'b1;
            for (int i = 7; i >= 0; i--) mq.push_back(din[i]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   bit a6[8]  = '{1,0,1,0,0,1,1,0};
   bit b2b[16] = '{1,0,1,0,0,1,1,0,0,0,1,1,1,1,0,0};
   bit b55[8] = '{0,1,0,1,0,1,0,1};

   task automatic test_reset();
      resetn = 1'b0; din = 8'hFF; din_valid = 1'b1; dout_ready = 1'b1;
      l_din = 8'h00; l_dv = 1'b0; l_drdy = 1'b1;
      w_din = 3'b000; w_dv = 1'b0; w_drdy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if ({dout, dout_valid, dout_last, din_ready} !== 4'b0000) begin
            bad++; $display("FAIL reset_outs cycle %0d: got %b want 0000", c, {dout, dout_valid, dout_last, din_ready});
         end
         total++;
         if ({l_dov, w_dov} !== 2'b00) begin
            bad++; $display("FAIL reset_variants cycle %0d: got %b want 00", c, {l_dov, w_dov});
         end
      end
      din_valid = 1'b0; resetn = 1'b1; #1;
      total++;
      if (din_ready !== 1'b1) begin
         bad++; $display("FAIL reset_idle_ready: got %b want 1", din_ready);
      end
   endtask

   task automatic test_single();
      din = 8'hA6; din_valid = 1'b1; dout_ready = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1; total++;
         if ({dout_valid, dout, dout_last} !== {1'b1, a6[i], (i == 7)}) begin
            bad++; $display("FAIL single bit %0d: got v/d/l=%b want %b", i, {dout_valid, dout, dout_last}, {1'b1, a6[i], (i == 7)});
         end
         tick();
      end
      total++;
      if (dout_valid !== 1'b0) begin
         bad++; $display("FAIL single_end_valid: got %b want 0", dout_valid);
      end
   endtask

   task automatic test_back_to_back();
      din = 8'hA6; din_valid = 1'b1; dout_ready = 1'b1;
      tick();
      din = 8'h3C;
      for (int i = 0; i < 16; i++) begin
         #1; total++;
         if ({dout_valid, dout, din_ready} !== {1'b1, b2b[i], (i == 7 || i == 15)}) begin
            bad++; $display("FAIL b2b bit %0d: got v/d/rdy=%b want %b", i, {dout_valid, dout, din_ready}, {1'b1, b2b[i], (i == 7 || i == 15)});
         end
         tick();
         if (i == 7) din_valid = 1'b0;
      end
      total++;
      if (dout_valid !== 1'b0) begin
         bad++; $display("FAIL b2b_end_valid: got %b want 0", dout_valid);
      end
   endtask

   task automatic test_backpressure();
      din = 8'hA6; din_valid = 1'b1; dout_ready = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            dout_ready = 1'b0;
            for (int h = 0; h < 2; h++) begin
               #1; total++;
               if ({dout_valid, dout, dout_last} !== 3'b110) begin
                  bad++; $display("FAIL bp_hold %0d: got v/d/l=%b want 110", h, {dout_valid, dout, dout_last});
               end
               tick();
            end
            dout_ready = 1'b1;
         end
         #1; total++;
         if ({dout_valid, dout, dout_last} !== {1'b1, a6[i], (i == 7)}) begin
            bad++; $display("FAIL bp bit %0d: got v/d/l=%b want %b", i, {dout_valid, dout, dout_last}, {1'b1, a6[i], (i == 7)});
         end
         tick();
      end
   endtask

   task automatic test_busy();
      din = 8'hA6; din_valid = 1'b1; dout_ready = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin din = 8'h55; din_valid = 1'b1; end
         #1; total++;
         if ({dout, din_ready} !== {a6[i], (i == 7)}) begin
            bad++; $display("FAIL busy bit %0d: got d/rdy=%b want %b", i, {dout, din_ready}, {a6[i], (i == 7)});
         end
         tick();
      end
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1; total++;
         if ({dout_valid, dout, dout_last} !== {1'b1, b55[i], (i == 7)}) begin
            bad++; $display("FAIL busy_55 bit %0d: got v/d/l=%b want %b", i, {dout_valid, dout, dout_last}, {1'b1, b55[i], (i == 7)});
         end
         tick();
      end
   endtask

   task automatic test_variants();
      l_din = 8'h01; l_dv = 1'b1;
      w_din = 3'b110; w_dv = 1'b1;
      tick();
      l_dv = 1'b0; w_dv = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1; total++;
         if ({l_dov, l_do, l_last} !== {1'b1, (i == 0), (i == 7)}) begin
            bad++; $display("FAIL lsb bit %0d: got v/d/l=%b want %b", i, {l_dov, l_do, l_last}, {1'b1, (i == 0), (i == 7)});
         end
         if (i < 3) begin
            total++;
            if ({w_dov, w_do, w_last} !== {1'b1, (i != 2), (i == 2)}) begin
               bad++; $display("FAIL w3 bit %0d: got v/d/l=%b want %b", i, {w_dov, w_do, w_last}, {1'b1, (i != 2), (i == 2)});
            end
         end
         tick();
      end
      total++;
      if ({l_dov, w_dov} !== 2'b00) begin
         bad++; $display("FAIL variants_end: got %b want 00", {l_dov, w_dov});
      end
   endtask

   task automatic test_reset_mid();
      din = 8'hA6; din_valid = 1'b1; dout_ready = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      resetn = 1'b0;
      tick();
      total++;
      if ({dout_valid, dout, din_ready} !== 3'b000) begin
         bad++; $display("FAIL reset_mid: got v/d/rdy=%b want 000", {dout_valid, dout, din_ready});
      end
      resetn = 1'b1; din = 8'hFF; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1; total++;
         if ({dout_valid, dout, dout_last} !== {2'b11, (i == 7)}) begin
            bad++; $display("FAIL reset_mid_ff bit %0d: got v/d/l=%b want %b", i, {dout_valid, dout, dout_last}, {2'b11, (i == 7)});
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         if (!(din_valid && !last_acc)) begin
            din_valid = ($urandom_range(0, 3) != 0);
            din = 8'($urandom);
         end
         dout_ready = ($urandom_range(0, 3) != 0);
         resetn = ($urandom_range(0, 99) != 0);
         #1; total++;
         if ({dout_valid, dout, dout_last, din_ready} !== {m_valid(), m_dout(), m_last(), m_ready()}) begin
            bad++; $display("FAIL random cycle %0d: got v/d/l/rdy=%b want %b", c,
                            {dout_valid, dout, dout_last, din_ready}, {m_valid(), m_dout(), m_last(), m_ready()});
         end
         tick();
      end
      resetn = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_busy();
      test_variants();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
